// File: rtl/seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder
//
// Receive side of the 7-segment display path. Samples a multiplexed display
// bus (one-hot digit select + 7 segment lines), waits for each digit's
// pattern to be stable for STABLE_CYCLES samples, decodes it back to BCD and
// assembles a frame of NUM_DIGITS digits. Completed frames are presented
// with a valid/ready handshake together with per-digit blank/error flags.
//
// Parameters:
//   NUM_DIGITS    - digits per frame (1..8)
//   STABLE_CYCLES - identical consecutive samples required before capture (>=1)
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   dig_sel      in   [NUM_DIGITS-1:0] one-hot digit select
//   seg_in       in   [6:0] segment lines, bit6=a ... bit0=g
//   frame_valid  out  a complete frame is held on the outputs
//   frame_ready  in   consumer accepts the frame when valid && ready
//   bcd_out      out  [4*NUM_DIGITS-1:0] digit i on bits [4i+3:4i]
//   blank_mask   out  [NUM_DIGITS-1:0] digit i was all-off (nibble = 0)
//   err_mask     out  [NUM_DIGITS-1:0] digit i was not decodable (nibble = F)
//   overrun      out  sticky: a completed frame was dropped under backpressure
//
// Build option:
//   SEG_ACTIVE_LOW_EN - when defined, dig_sel and seg_in are active low
//                       (common-anode panels) and are inverted right after
//                       the input register.
// ---------------------------------------------------------------------------
module seg7_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_DIGITS-1:0]   dig_sel,
   input  logic [6:0]              seg_in,
   output logic                    frame_valid,
   input  logic                    frame_ready,
   output logic [4*NUM_DIGITS-1:0] bcd_out,
   output logic [NUM_DIGITS-1:0]   blank_mask,
   output logic [NUM_DIGITS-1:0]   err_mask,
   output logic                    overrun
);

   localparam int CNT_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYCLES);

   localparam logic [1:0] S_SCAN    = 2'd0;
   localparam logic [1:0] S_SETTLE  = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_HOLD    = 2'd3;

`ifdef SEG_ACTIVE_LOW_EN
   // Idle level of an active-low bus is all ones.
   localparam logic [NUM_DIGITS-1:0] SEL_IDLE = '1;
   localparam logic [6:0]            SEG_IDLE = '1;
`else
   localparam logic [NUM_DIGITS-1:0] SEL_IDLE = '0;
   localparam logic [6:0]            SEG_IDLE = '0;
`endif

   // ------------------------------------------------------------------
   // Input register and polarity normalisation
   // ------------------------------------------------------------------
   logic [NUM_DIGITS-1:0] sel_r;
   logic [6:0]            seg_r;
   logic [NUM_DIGITS-1:0] sel_v;
   logic [6:0]            seg_v;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sel_r <= SEL_IDLE;
         seg_r <= SEG_IDLE;
      end else begin
         sel_r <= dig_sel;
         seg_r <= seg_in;
      end
   end

`ifdef SEG_ACTIVE_LOW_EN
   assign sel_v = ~sel_r;
   assign seg_v = ~seg_r;
`else
   assign sel_v = sel_r;
   assign seg_v = seg_r;
`endif

   // ------------------------------------------------------------------
   // Segment decode: returns {blank, err, bcd[3:0]}
   // ------------------------------------------------------------------
   function automatic logic [5:0] decode_seg(input logic [6:0] seg);
      logic [5:0] r;
      case (seg)
         7'h7E:   r = 6'b00_0000;
         7'h30:   r = 6'b00_0001;
         7'h6D:   r = 6'b00_0010;
         7'h79:   r = 6'b00_0011;
         7'h33:   r = 6'b00_0100;
         7'h5B:   r = 6'b00_0101;
         7'h5F:   r = 6'b00_0110;
         7'h70:   r = 6'b00_0111;
         7'h7F:   r = 6'b00_1000;
         7'h7B:   r = 6'b00_1001;
         7'h00:   r = 6'b10_0000;
         default: r = 6'b01_1111;
      endcase
      return r;
   endfunction

   // ------------------------------------------------------------------
   // Scan FSM state
   // ------------------------------------------------------------------
   logic [1:0]            state, state_n;
   logic [CNT_W-1:0]      cnt, cnt_n;
   logic [NUM_DIGITS-1:0] lat_sel, lat_sel_n;
   logic [6:0]            lat_seg, lat_seg_n;

   logic                  sel_one_hot;
   logic                  sample_same;

   assign sel_one_hot = ($countones(sel_v) == 1);
   assign sample_same = (sel_v == lat_sel) && (seg_v == lat_seg);

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      lat_sel_n = lat_sel;
      lat_seg_n = lat_seg;
      case (state)
         S_SCAN: begin
            if (sel_one_hot) begin
               lat_sel_n = sel_v;
               lat_seg_n = seg_v;
               cnt_n     = CNT_ONE;
               // A single required sample means this sample is already stable.
               state_n   = (STABLE_CYCLES <= 1) ? S_CAPTURE : S_SETTLE;
            end else begin
               cnt_n = '0;
            end
         end
         S_SETTLE: begin
            if (sample_same) begin
               cnt_n = cnt + CNT_ONE;
               if (cnt_n == CNT_TARGET) state_n = S_CAPTURE;
            end else if (sel_one_hot) begin
               lat_sel_n = sel_v;
               lat_seg_n = seg_v;
               cnt_n     = CNT_ONE;
               state_n   = (STABLE_CYCLES <= 1) ? S_CAPTURE : S_SETTLE;
            end else begin
               cnt_n   = '0;
               state_n = S_SCAN;
            end
         end
         S_CAPTURE: begin
            state_n = S_HOLD;
         end
         default: begin
            // S_HOLD: one capture per dwell; leave once the select moves.
            if (sel_v != lat_sel) begin
               cnt_n   = '0;
               state_n = S_SCAN;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_SCAN;
         cnt     <= '0;
         lat_sel <= '0;
         lat_seg <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         lat_sel <= lat_sel_n;
         lat_seg <= lat_seg_n;
      end
   end

   // ------------------------------------------------------------------
   // Working frame assembly
   // ------------------------------------------------------------------
   logic [4*NUM_DIGITS-1:0] work_bcd,   work_bcd_upd;
   logic [NUM_DIGITS-1:0]   work_blank, work_blank_upd;
   logic [NUM_DIGITS-1:0]   work_err,   work_err_upd;
   logic [NUM_DIGITS-1:0]   captured,   captured_upd;
   logic [5:0]              dec;
   logic                    capture;
   logic                    complete;
   logic                    load_out;

   assign dec     = decode_seg(lat_seg);
   assign capture = (state == S_CAPTURE);

   // Working frame with the current capture merged in; the output copy
   // takes this merged view so the frame appears the cycle after CAPTURE.
   always_comb begin
      work_bcd_upd   = work_bcd;
      work_blank_upd = work_blank;
      work_err_upd   = work_err;
      captured_upd   = captured;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (lat_sel[i]) begin
            work_bcd_upd[4*i +: 4] = dec[3:0];
            work_blank_upd[i]      = dec[5];
            work_err_upd[i]        = dec[4];
            captured_upd[i]        = 1'b1;
         end
      end
   end

   assign complete = capture && (&captured_upd);
   assign load_out = complete && (!frame_valid || frame_ready);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         work_bcd   <= '0;
         work_blank <= '0;
         work_err   <= '0;
         captured   <= '0;
      end else if (capture) begin
         work_bcd   <= work_bcd_upd;
         work_blank <= work_blank_upd;
         work_err   <= work_err_upd;
         captured   <= complete ? '0 : captured_upd;
      end
   end

   // ------------------------------------------------------------------
   // Output frame and handshake
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_valid <= 1'b0;
         bcd_out     <= '0;
         blank_mask  <= '0;
         err_mask    <= '0;
         overrun     <= 1'b0;
      end else if (load_out) begin
         // Also covers completion in the same cycle as acceptance.
         frame_valid <= 1'b1;
         bcd_out     <= work_bcd_upd;
         blank_mask  <= work_blank_upd;
         err_mask    <= work_err_upd;
      end else begin
         if (complete) overrun <= 1'b1;
         if (frame_valid && frame_ready) frame_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
module tb_seg7_scan_decoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  dig_sel;
   logic [6:0]  seg_in;
   logic        frame_valid;
   logic        frame_ready;
   logic [15:0] bcd_out;
   logic [3:0]  blank_mask;
   logic [3:0]  err_mask;
   logic        overrun;

   always #5 clk = ~clk;

   seg7_scan_decoder #(
      .NUM_DIGITS    (4),
      .STABLE_CYCLES (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .dig_sel     (dig_sel),
      .seg_in      (seg_in),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .bcd_out     (bcd_out),
      .blank_mask  (blank_mask),
      .err_mask    (err_mask),
      .overrun     (overrun)
   );

   typedef struct packed {
      logic [6:0]  s3;
      logic [6:0]  s2;
      logic [6:0]  s1;
      logic [6:0]  s0;
      logic [15:0] bcd;
      logic [3:0]  blank;
      logic [3:0]  err;
   } vec_t;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Handshake monitor, sampled on the falling edge.
   int          hs_cnt = 0;
   logic [15:0] hs_bcd = '0;
   logic [3:0]  hs_blank = '0;
   logic [3:0]  hs_err = '0;

   always @(negedge clk) begin
      if (frame_valid && frame_ready) begin
         hs_cnt   <= hs_cnt + 1;
         hs_bcd   <= bcd_out;
         hs_blank <= blank_mask;
         hs_err   <= err_mask;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %0h required %0h", name, act, req);
   endtask

   // All stimulus tasks start and end at posedge+1.
   task automatic send_digit(input int idx, input logic [6:0] seg, input int cycles);
      dig_sel = 4'(1 << idx);
      seg_in  = seg;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int cycles);
      dig_sel = '0;
      seg_in  = '0;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input vec_t v);
      send_digit(0, v.s0, 20);
      send_digit(1, v.s1, 20);
      send_digit(2, v.s2, 20);
      send_digit(3, v.s3, 20);
      idle(4);
   endtask

   vec_t vecs [5];
   int   hs_before;

   initial begin
      vecs[0] = '{s3:7'h33, s2:7'h79, s1:7'h6D, s0:7'h30, bcd:16'h4321, blank:4'b0000, err:4'b0000};
      vecs[1] = '{s3:7'h01, s2:7'h00, s1:7'h7F, s0:7'h7E, bcd:16'hF080, blank:4'b0100, err:4'b1000};
      vecs[2] = '{s3:7'h7B, s2:7'h01, s1:7'h00, s0:7'h5B, bcd:16'h9F05, blank:4'b0010, err:4'b0100};
      vecs[3] = '{s3:7'h7E, s2:7'h7B, s1:7'h70, s0:7'h5F, bcd:16'h0976, blank:4'b0000, err:4'b0000};
      vecs[4] = '{s3:7'h7F, s2:7'h7F, s1:7'h7F, s0:7'h7F, bcd:16'h8888, blank:4'b0000, err:4'b0000};

      // Reset with a valid-looking digit on the bus.
      rst_n       = 1'b0;
      dig_sel     = 4'b0001;
      seg_in      = 7'h7E;
      frame_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid",   32'(frame_valid), 32'h0);
      check("rst_bcd",     32'(bcd_out),     32'h0);
      check("rst_blank",   32'(blank_mask),  32'h0);
      check("rst_err",     32'(err_mask),    32'h0);
      check("rst_overrun", 32'(overrun),     32'h0);
      rst_n = 1'b1;
      idle(3);
      check("rst_no_frame", 32'(hs_cnt), 32'h0);

      // Table-driven clean frames.
      for (int k = 0; k < 5; k++) begin
         hs_before = hs_cnt;
         send_frame(vecs[k]);
         check($sformatf("vec%0d_pulses", k),  32'(hs_cnt - hs_before), 32'h1);
         check($sformatf("vec%0d_bcd", k),     32'(hs_bcd),   32'(vecs[k].bcd));
         check($sformatf("vec%0d_blank", k),   32'(hs_blank), 32'(vecs[k].blank));
         check($sformatf("vec%0d_err", k),     32'(hs_err),   32'(vecs[k].err));
         check($sformatf("vec%0d_overrun", k), 32'(overrun),  32'h0);
      end

      // Glitch: digit0 toggles 7E/7F every 3 cycles, then settles on 7F.
      hs_before = hs_cnt;
      for (int k = 0; k < 4; k++) send_digit(0, (k % 2 == 1) ? 7'h7F : 7'h7E, 3);
      send_digit(0, 7'h7F, 20);
      send_digit(1, 7'h30, 20);
      send_digit(2, 7'h6D, 20);
      send_digit(3, 7'h79, 20);
      idle(4);
      check("glitch_pulses", 32'(hs_cnt - hs_before), 32'h1);
      check("glitch_bcd",    32'(hs_bcd),             32'h3218);

      // Illegal select while digit2 is the only one missing.
      hs_before = hs_cnt;
      send_digit(0, 7'h30, 20);
      send_digit(1, 7'h6D, 20);
      send_digit(3, 7'h33, 20);
      dig_sel = 4'b0110;
      seg_in  = 7'h7F;
      repeat (30) @(posedge clk);
      #1;
      check("illegal_no_frame", 32'(hs_cnt - hs_before), 32'h0);
      check("illegal_valid",    32'(frame_valid),        32'h0);
      send_digit(2, 7'h79, 20);
      idle(4);
      check("illegal_then_pulses", 32'(hs_cnt - hs_before), 32'h1);
      check("illegal_then_bcd",    32'(hs_bcd),             32'h4321);

      // Backpressure across two complete frames.
      hs_before   = hs_cnt;
      frame_ready = 1'b0;
      send_frame(vecs[0]);
      send_frame(vecs[3]);
      check("bp_valid",    32'(frame_valid),        32'h1);
      check("bp_bcd_held", 32'(bcd_out),            32'h4321);
      check("bp_overrun",  32'(overrun),            32'h1);
      check("bp_no_hs",    32'(hs_cnt - hs_before), 32'h0);
      frame_ready = 1'b1;
      @(negedge clk);
      check("bp_valid_until_edge", 32'(frame_valid), 32'h1);
      @(posedge clk);
      #1;
      check("bp_valid_dropped", 32'(frame_valid),        32'h0);
      check("bp_overrun_stick", 32'(overrun),            32'h1);
      check("bp_hs_bcd",        32'(hs_bcd),             32'h4321);
      check("bp_hs_once",       32'(hs_cnt - hs_before), 32'h1);

      // Reset mid-frame after two digits.
      idle(2);
      send_digit(0, 7'h5B, 20);
      send_digit(1, 7'h5F, 20);
      dig_sel = '0;
      rst_n   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("mid_rst_overrun", 32'(overrun), 32'h0);
      hs_before = hs_cnt;
      send_digit(2, 7'h70, 20);
      send_digit(3, 7'h7B, 20);
      idle(4);
      check("mid_rst_no_frame", 32'(hs_cnt - hs_before), 32'h0);
      check("mid_rst_valid",    32'(frame_valid),        32'h0);
      send_digit(0, 7'h7E, 20);
      send_digit(1, 7'h30, 20);
      idle(4);
      check("mid_rst_pulses", 32'(hs_cnt - hs_before), 32'h1);
      check("mid_rst_bcd",    32'(hs_bcd),             32'h9710);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
